// File: rtl/gcd_unit_param.sv
// gcd_unit_param: repeated-subtraction GCD with start/busy/done handshake and held result.
// Define GCD_CYCLES_EN to expose the per-job subtraction-step count on port 'cycles'.
module gcd_unit_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] xin,
    input  logic [WIDTH-1:0] yin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic             err
`ifdef GCD_CYCLES_EN
    ,
    output logic [WIDTH-1:0] cycles
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] x, y;
    logic             fin;
    logic             accept;

    // Zero operands and x==y all finish in one step without subtracting.
    assign fin    = (x == '0) || (y == '0) || (x == y);
    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (fin)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            x <= xin;
            y <= yin;
        end else if (state == CALC && !fin) begin
            if (x > y) x <= x - y;
            else       y <= y - x;
        end
    end

    // With one operand zero the other is the answer; both zero yields 0 with err.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            gcd <= '0;
            err <= 1'b0;
        end else if (state == CALC && fin) begin
            gcd <= (x == '0) ? y : x;
            err <= (x == '0) && (y == '0);
        end
    end

`ifdef GCD_CYCLES_EN
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt    <= '0;
            cycles <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == CALC) begin
            if (fin) cycles <= cnt;
            else     cnt    <= cnt + WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gcd_unit_param.sv
// Scoreboard bench for gcd_unit_param: an 8-bit and a 16-bit instance checked against a Euclid model.
// Build with +define+GCD_CYCLES_EN to also check the cycles port.
module tb_gcd_unit_param;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s8 = 1'b0, s16 = 1'b0;
    logic [7:0]  x8 = '0, y8 = '0, g8;
    logic [15:0] x16 = '0, y16 = '0, g16;
    logic        b8, d8, e8, b16, d16, e16;
`ifdef GCD_CYCLES_EN
    logic [7:0]  c8;
    logic [15:0] c16;
`endif

    gcd_unit_param #(.WIDTH(8)) u8 (
        .clk(clk), .clr_n(clr_n), .start(s8), .xin(x8), .yin(y8),
        .busy(b8), .done(d8), .gcd(g8), .err(e8)
`ifdef GCD_CYCLES_EN
        , .cycles(c8)
`endif
    );

    gcd_unit_param #(.WIDTH(16)) u16 (
        .clk(clk), .clr_n(clr_n), .start(s16), .xin(x16), .yin(y16),
        .busy(b16), .done(d16), .gcd(g16), .err(e16)
`ifdef GCD_CYCLES_EN
        , .cycles(c16)
`endif
    );

    typedef struct {
        int unsigned g;
        bit          er;
        int unsigned n;
        int unsigned at;
    } exp_t;

    exp_t q8[$], q16[$];
    int   errors = 0, checks = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Euclid by division: each quotient is a run of subtractions; the last run stops one short at x==y.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned acc);
        exp_t        r;
        int unsigned t;
        r.er = (a == 0) && (b == 0);
        r.n  = 0;
        if (a == 0 || b == 0) begin
            r.g = a + b;
        end else begin
            while (b != 0) begin
                r.n += a / b;
                t = a % b;
                a = b;
                b = t;
            end
            r.g = a;
            r.n -= 1;
        end
        r.at = acc + r.n + 1;
        return r;
    endfunction

    logic [15:0] gv[2];
    logic        bv[2], dv[2], ev[2];
    assign gv[0] = {8'h00, g8};
    assign gv[1] = g16;
    assign bv[0] = b8;  assign bv[1] = b16;
    assign dv[0] = d8;  assign dv[1] = d16;
    assign ev[0] = e8;  assign ev[1] = e16;
`ifdef GCD_CYCLES_EN
    logic [15:0] cv[2];
    assign cv[0] = {8'h00, c8};
    assign cv[1] = c16;
`endif

    int unsigned hg[2], bc[2];
    bit          he[2], pd[2];

    task automatic mon(input int u);
        exp_t  e;
        int    qs;
        string nm;
        nm = (u != 0) ? "w16" : "w8";
        if (!clr_n) begin
            hg[u] = 0; he[u] = 0; bc[u] = 0; pd[u] = 0;
            chk({nm, " reset busy"}, longint'(bv[u]), 0);
            chk({nm, " reset done"}, longint'(dv[u]), 0);
            chk({nm, " reset gcd"},  longint'(gv[u]), 0);
            chk({nm, " reset err"},  longint'(ev[u]), 0);
`ifdef GCD_CYCLES_EN
            chk({nm, " reset cycles"}, longint'(cv[u]), 0);
`endif
            return;
        end
        if (bv[u]) bc[u]++;
        if (dv[u]) begin
            qs = (u != 0) ? q16.size() : q8.size();
            chk({nm, " done width"}, longint'(pd[u]), 0);
            chk({nm, " done expected"}, longint'(qs != 0), 1);
            if (qs != 0) begin
                e = (u != 0) ? q16.pop_front() : q8.pop_front();
                chk({nm, " gcd"}, longint'(gv[u]), longint'(e.g));
                chk({nm, " err"}, longint'(ev[u]), longint'(e.er));
                chk({nm, " done cycle"}, longint'(cyc), longint'(e.at));
                chk({nm, " busy cycles"}, longint'(bc[u]), longint'(e.n + 1));
`ifdef GCD_CYCLES_EN
                chk({nm, " cycles"}, longint'(cv[u]), longint'(e.n));
`endif
                hg[u] = e.g;
                he[u] = e.er;
            end
            bc[u] = 0;
        end else begin
            chk({nm, " gcd hold"}, longint'(gv[u]), longint'(hg[u]));
            chk({nm, " err hold"}, longint'(ev[u]), longint'(he[u]));
        end
        pd[u] = dv[u];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic wait_idle(input bit w);
        int k = 0;
        @(negedge clk);
        while ((w ? (b16 | d16) : (b8 | d8)) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("idle timeout", longint'(k < 5000), 1);
    endtask

    task automatic job(input bit w, input int unsigned a, input int unsigned b);
        wait_idle(w);
        if (w) begin
            s16 = 1'b1; x16 = a[15:0]; y16 = b[15:0];
            q16.push_back(model(a, b, cyc + 1));
            @(negedge clk);
            s16 = 1'b0;
        end else begin
            s8 = 1'b1; x8 = a[7:0]; y8 = b[7:0];
            q8.push_back(model(a, b, cyc + 1));
            @(negedge clk);
            s8 = 1'b0;
        end
    endtask

    initial begin
        exp_t        e1;
        int unsigned a, b, c;
        int          k;
        #20 clr_n = 1'b1;

        job(0, 228, 52);
        job(0, 52, 52);
        job(0, 45, 139);
        job(0, 0, 36);
        job(0, 0, 0);
        job(0, 12, 18);
        job(0, 36, 0);

        // Start pulsed mid-job with other operands must be ignored.
        job(0, 228, 52);
        c = cyc;
        while (cyc < c + 2) @(negedge clk);
        s8 = 1'b1; x8 = 8'd9; y8 = 8'd6;
        @(negedge clk);
        s8 = 1'b0;

        // Start held high: second job accepted on the first IDLE edge after done.
        wait_idle(0);
        s8 = 1'b1; x8 = 8'd100; y8 = 8'd75;
        e1 = model(100, 75, cyc + 1);
        q8.push_back(e1);
        q8.push_back(model(100, 75, e1.at + 2));
        while (cyc < e1.at + 2) @(negedge clk);
        s8 = 1'b0;

        // Abort mid-job with reset: no done, outputs back to reset values.
        wait_idle(0);
        s8 = 1'b1; x8 = 8'd228; y8 = 8'd52;
        c = cyc;
        @(negedge clk);
        s8 = 1'b0;
        while (cyc < c + 4) @(negedge clk);
        @(posedge clk);
        #2 clr_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 clr_n = 1'b1;
        repeat (3) @(negedge clk);

        job(1, 65535, 255);
        job(1, 0, 1000);
        job(1, 1, 1);

        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            job(0, a, b);
        end
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(1, 1023);
            b = $urandom_range(1, 1023);
            job(1, a, b);
        end

        k = 0;
        while ((q8.size() != 0 || q16.size() != 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("drain w8", longint'(q8.size()), 0);
        chk("drain w16", longint'(q16.size()), 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
